// File: rtl/pe_seq_ctrl_pkg.sv
// Shared constants and types for the PE microcode sequencer.
// Config word layout: ten 2-bit mux selects, two add/sub ops, integer mode, rounding.
package pe_ctrl_pkg;

  localparam int CFG_W       = 26;
  localparam int OP_W        = 32;
  localparam int MSEL_N      = 10;
  localparam int MSEL_W      = 2;
  localparam int ADDSUB0_BIT = 20;
  localparam int ADDSUB1_BIT = 21;
  localparam int USE_INT_BIT = 22;
  localparam int ROUND_LSB   = 23;
  localparam int ROUND_W     = 3;
  localparam int REP_W       = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic logic [MSEL_W-1:0] cfg_msel(input logic [CFG_W-1:0] cfg, input int k);
    return cfg[k*MSEL_W +: MSEL_W];
  endfunction

endpackage

// File: rtl/pe_seq_ctrl_if.sv
// Bus bundle between the sequencer and its host/PE: table writes, program
// control, operand handshake, registered PE config/operands and result tracking.
interface pe_seq_ctrl_if
  import pe_ctrl_pkg::*;
#(
  parameter int AW = 4
);
  logic                 io_cfg_wen;
  logic [AW-1:0]        io_cfg_waddr;
  logic [CFG_W-1:0]     io_cfg_wdata;
  logic                 io_start;
  logic [AW-1:0]        io_first;
  logic [AW-1:0]        io_last;
  logic [REP_W-1:0]     io_repeat;
  logic                 io_busy;
  logic                 io_done;
  logic                 io_in_valid;
  logic                 io_in_ready;
  logic [OP_W-1:0]      io_Xi_0, io_Yi_0, io_Xi_1, io_Yi_1;
  logic [OP_W-1:0]      io_pe_Xi_0, io_pe_Yi_0, io_pe_Xi_1, io_pe_Yi_1;
  logic [MSEL_W-1:0]    io_m_0_sel, io_m_1_sel, io_m_2_sel, io_m_3_sel, io_m_4_sel;
  logic [MSEL_W-1:0]    io_m_5_sel, io_m_6_sel, io_m_7_sel, io_m_8_sel, io_m_9_sel;
  logic                 io_addsub_0_op, io_addsub_1_op, io_use_int;
  logic [ROUND_W-1:0]   io_round;
  logic                 io_out_valid;
  logic [AW-1:0]        io_out_step;

  modport master (
    output io_cfg_wen, io_cfg_waddr, io_cfg_wdata, io_start, io_first, io_last, io_repeat,
           io_in_valid, io_Xi_0, io_Yi_0, io_Xi_1, io_Yi_1,
    input  io_busy, io_done, io_in_ready, io_pe_Xi_0, io_pe_Yi_0, io_pe_Xi_1, io_pe_Yi_1,
           io_m_0_sel, io_m_1_sel, io_m_2_sel, io_m_3_sel, io_m_4_sel,
           io_m_5_sel, io_m_6_sel, io_m_7_sel, io_m_8_sel, io_m_9_sel,
           io_addsub_0_op, io_addsub_1_op, io_use_int, io_round, io_out_valid, io_out_step
  );

  modport slave (
    input  io_cfg_wen, io_cfg_waddr, io_cfg_wdata, io_start, io_first, io_last, io_repeat,
           io_in_valid, io_Xi_0, io_Yi_0, io_Xi_1, io_Yi_1,
    output io_busy, io_done, io_in_ready, io_pe_Xi_0, io_pe_Yi_0, io_pe_Xi_1, io_pe_Yi_1,
           io_m_0_sel, io_m_1_sel, io_m_2_sel, io_m_3_sel, io_m_4_sel,
           io_m_5_sel, io_m_6_sel, io_m_7_sel, io_m_8_sel, io_m_9_sel,
           io_addsub_0_op, io_addsub_1_op, io_use_int, io_round, io_out_valid, io_out_step
  );

endinterface

// File: rtl/pe_ctrl_lat_pipe.sv
// Fixed-latency delay line of {valid, step} mirroring the PE pipeline depth.
// Output is the last stage; empty means nothing is in flight anywhere.
module pe_ctrl_lat_pipe #(
  parameter int AW  = 4,
  parameter int LAT = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic [AW-1:0] push_step,
  output logic          out_valid,
  output logic [AW-1:0] out_step,
  output logic          empty
);

  logic [LAT-1:0] vld_q, vld_d;
  logic [AW-1:0]  step_q [LAT];
  logic [AW-1:0]  step_d [LAT];

  always_comb begin
    vld_d[0]  = push;
    step_d[0] = push ? push_step : '0;
    for (int i = 1; i < LAT; i++) begin
      vld_d[i]  = vld_q[i-1];
      step_d[i] = step_q[i-1];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q <= '0;
      for (int i = 0; i < LAT; i++) step_q[i] <= '0;
    end else begin
      vld_q  <= vld_d;
      step_q <= step_d;
    end
  end

  assign out_valid = vld_q[LAT-1];
  assign out_step  = step_q[LAT-1];
  assign empty     = ~|vld_q;

endmodule

// File: rtl/pe_seq_ctrl.sv
// Microcoded sequencer: steps a range of config-table entries, one per accepted
// operand set, registering config and operands together for the PE.
//
// state | meaning
// IDLE  | waiting for start; table writable
// RUN   | issuing one table entry per operand handshake
// DRAIN | all steps issued; waiting for the last result to retire
module pe_seq_ctrl
  import pe_ctrl_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int LAT   = 3
) (
  input logic          clock,
  input logic          reset,
  pe_seq_ctrl_if.slave io
);

  localparam int AW = $clog2(DEPTH);

  state_t            state_q, state_d;
  logic [AW-1:0]     ptr_q, ptr_d, first_q, first_d, last_q, last_d;
  logic [REP_W-1:0]  rep_q, rep_d;
  logic [CFG_W-1:0]  cfg_q, cfg_d;
  logic [OP_W-1:0]   x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
  logic [CFG_W-1:0]  tbl_q [DEPTH];

  logic in_ready, busy, done;
  logic hs, start_ok, tbl_we, at_last, lat_empty;

  // state register
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  assign hs       = io.io_in_valid && in_ready;
  assign at_last  = (ptr_q == last_q);
  // The done cycle already counts as idle, so a new program may start there.
  assign start_ok = io.io_start && (io.io_first <= io.io_last) && ((state_q == IDLE) || done);
  assign tbl_we   = io.io_cfg_wen && !busy;

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = RUN;
      RUN:     if (hs && at_last && (rep_q == '0)) state_d = DRAIN;
      DRAIN:   if (lat_empty) state_d = start_ok ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // output logic
  always_comb begin
    in_ready = (state_q == RUN);
    done     = (state_q == DRAIN) && lat_empty;
    busy     = (state_q == RUN) || ((state_q == DRAIN) && !lat_empty);
  end

  always_comb begin
    ptr_d   = ptr_q;
    first_d = first_q;
    last_d  = last_q;
    rep_d   = rep_q;
    if (start_ok) begin
      ptr_d   = io.io_first;
      first_d = io.io_first;
      last_d  = io.io_last;
      rep_d   = io.io_repeat;
    end else if (hs) begin
      if (!at_last) begin
        ptr_d = ptr_q + 1'b1;
      end else if (rep_q != '0) begin
        ptr_d = first_q;
        rep_d = rep_q - 1'b1;
      end
    end
  end

  always_comb begin
    cfg_d = cfg_q;
    x0_d  = x0_q;
    y0_d  = y0_q;
    x1_d  = x1_q;
    y1_d  = y1_q;
    if (hs) begin
      cfg_d = tbl_q[ptr_q];
      x0_d  = io.io_Xi_0;
      y0_d  = io.io_Yi_0;
      x1_d  = io.io_Xi_1;
      y1_d  = io.io_Yi_1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q   <= '0;
      first_q <= '0;
      last_q  <= '0;
      rep_q   <= '0;
      cfg_q   <= '0;
      x0_q    <= '0;
      y0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
    end else begin
      ptr_q   <= ptr_d;
      first_q <= first_d;
      last_q  <= last_d;
      rep_q   <= rep_d;
      cfg_q   <= cfg_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
    end
  end

  // Table survives reset so a program can be rerun after an abort.
  always_ff @(posedge clock) begin
    if (tbl_we) tbl_q[io.io_cfg_waddr] <= io.io_cfg_wdata;
  end

  pe_ctrl_lat_pipe #(
    .AW  (AW),
    .LAT (LAT)
  ) u_lat_pipe (
    .clock     (clock),
    .reset     (reset),
    .push      (hs),
    .push_step (ptr_q),
    .out_valid (io.io_out_valid),
    .out_step  (io.io_out_step),
    .empty     (lat_empty)
  );

  assign io.io_busy     = busy;
  assign io.io_done     = done;
  assign io.io_in_ready = in_ready;

  assign io.io_pe_Xi_0 = x0_q;
  assign io.io_pe_Yi_0 = y0_q;
  assign io.io_pe_Xi_1 = x1_q;
  assign io.io_pe_Yi_1 = y1_q;

  assign io.io_m_0_sel     = cfg_msel(cfg_q, 0);
  assign io.io_m_1_sel     = cfg_msel(cfg_q, 1);
  assign io.io_m_2_sel     = cfg_msel(cfg_q, 2);
  assign io.io_m_3_sel     = cfg_msel(cfg_q, 3);
  assign io.io_m_4_sel     = cfg_msel(cfg_q, 4);
  assign io.io_m_5_sel     = cfg_msel(cfg_q, 5);
  assign io.io_m_6_sel     = cfg_msel(cfg_q, 6);
  assign io.io_m_7_sel     = cfg_msel(cfg_q, 7);
  assign io.io_m_8_sel     = cfg_msel(cfg_q, 8);
  assign io.io_m_9_sel     = cfg_msel(cfg_q, MSEL_N-1);
  assign io.io_addsub_0_op = cfg_q[ADDSUB0_BIT];
  assign io.io_addsub_1_op = cfg_q[ADDSUB1_BIT];
  assign io.io_use_int     = cfg_q[USE_INT_BIT];
  assign io.io_round       = cfg_q[ROUND_LSB +: ROUND_W];

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Scenario bench for pe_seq_ctrl: expected result steps are queued at issue time
// and retired by a monitor when io_out_valid appears.
module tb_pe_seq_ctrl;

  localparam int LAT = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  pe_seq_ctrl_if #(.AW(4)) bus ();

  pe_seq_ctrl #(.DEPTH(16), .LAT(LAT)) dut (
    .clock (clock),
    .reset (reset),
    .io    (bus)
  );

  typedef struct {
    int         due;
    logic [3:0] step;
  } sb_t;

  sb_t          sb[$];
  logic [25:0]  tbl_m [16];
  logic [25:0]  exp_cfg = '0;
  logic [127:0] exp_ops = '0;
  int           cyc = 0;
  int           checks = 0;
  int           errors = 0;
  int           done_cnt = 0;
  bit           mon_en = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [25:0] cfg_out();
    return {bus.io_round, bus.io_use_int, bus.io_addsub_1_op, bus.io_addsub_0_op,
            bus.io_m_9_sel, bus.io_m_8_sel, bus.io_m_7_sel, bus.io_m_6_sel, bus.io_m_5_sel,
            bus.io_m_4_sel, bus.io_m_3_sel, bus.io_m_2_sel, bus.io_m_1_sel, bus.io_m_0_sel};
  endfunction

  // Scoreboard and hold checks, sampled mid-cycle.
  always @(negedge clock) begin
    if (mon_en) begin
      checks++;
      if (cfg_out() !== exp_cfg) begin
        errors++;
        $display("FAIL pe_cfg cyc %0d: got %h expected %h", cyc, cfg_out(), exp_cfg);
      end
      checks++;
      if ({bus.io_pe_Xi_0, bus.io_pe_Yi_0, bus.io_pe_Xi_1, bus.io_pe_Yi_1} !== exp_ops) begin
        errors++;
        $display("FAIL pe_ops cyc %0d: got %h expected %h", cyc,
                 {bus.io_pe_Xi_0, bus.io_pe_Yi_0, bus.io_pe_Xi_1, bus.io_pe_Yi_1}, exp_ops);
      end
      if (bus.io_done === 1'b1) begin
        done_cnt++;
        checks++;
        if (bus.io_busy !== 1'b0) begin
          errors++;
          $display("FAIL busy_at_done cyc %0d: got %b expected 0", cyc, bus.io_busy);
        end
      end
      if (bus.io_out_valid === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL out_valid cyc %0d: got unexpected valid step %0d expected none", cyc, bus.io_out_step);
        end else begin
          sb_t e;
          e = sb.pop_front();
          if (e.due != cyc || bus.io_out_step !== e.step) begin
            errors++;
            $display("FAIL out_step: got step %0d at cyc %0d expected step %0d at cyc %0d",
                     bus.io_out_step, cyc, e.step, e.due);
          end
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        sb_t e;
        e = sb.pop_front();
        checks++;
        errors++;
        $display("FAIL out_missing cyc %0d: got no valid expected step %0d", cyc, e.step);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [25:0] d);
    bus.io_cfg_wen   = 1'b1;
    bus.io_cfg_waddr = a;
    bus.io_cfg_wdata = d;
    tick();
    bus.io_cfg_wen   = 1'b0;
    tbl_m[a] = d;
  endtask

  task automatic start(input logic [3:0] f, input logic [3:0] l, input logic [7:0] r);
    bus.io_start  = 1'b1;
    bus.io_first  = f;
    bus.io_last   = l;
    bus.io_repeat = r;
    tick();
    bus.io_start  = 1'b0;
  endtask

  task automatic issue(input bit v, input logic [3:0] step);
    logic [127:0] ops;
    ops = {$urandom, $urandom, $urandom, $urandom};
    bus.io_in_valid = v;
    {bus.io_Xi_0, bus.io_Yi_0, bus.io_Xi_1, bus.io_Yi_1} = ops;
    if (v) sb.push_back('{due: cyc + LAT, step: step});
    tick();
    if (v) begin
      exp_cfg = tbl_m[step];
      exp_ops = ops;
    end
    bus.io_in_valid = 1'b0;
  endtask

  task automatic wait_done(output int at);
    at = -1;
    for (int n = 0; n < 40; n++) begin
      if (bus.io_done === 1'b1) begin
        at = cyc;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++; if (bus.io_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.io_busy); end
    checks++; if (bus.io_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.io_done); end
    checks++; if (bus.io_in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", bus.io_in_ready); end
    checks++; if (bus.io_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.io_out_valid); end
    checks++; if (cfg_out() !== 26'd0) begin errors++; $display("FAIL reset_cfg: got %h expected 0", cfg_out()); end
    checks++; if (bus.io_pe_Xi_0 !== 32'd0) begin errors++; $display("FAIL reset_pe_x0: got %h expected 0", bus.io_pe_Xi_0); end
    reset = 1'b0;
    mon_en = 1;
  endtask

  task automatic test_basic();
    int dc0, due_last, at;
    dc0 = done_cnt;
    start(4'd0, 4'd3, 8'd0);
    checks++; if (bus.io_busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", bus.io_busy); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.io_in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready step %0d: got %b expected 1", i, bus.io_in_ready); end
      due_last = cyc + LAT;
      issue(1'b1, i[3:0]);
    end
    checks++; if (bus.io_in_ready !== 1'b0) begin errors++; $display("FAIL basic_drain_ready: got %b expected 0", bus.io_in_ready); end
    wait_done(at);
    checks++; if (at != due_last + 1) begin errors++; $display("FAIL basic_done_cyc: got %0d expected %0d", at, due_last + 1); end
    tick();
    checks++; if (bus.io_done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b expected 0", bus.io_done); end
    checks++; if (done_cnt - dc0 != 1) begin errors++; $display("FAIL basic_done_cnt: got %0d expected 1", done_cnt - dc0); end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL basic_sb_left: got %0d expected 0", sb.size()); end
  endtask

  task automatic test_repeat();
    int dc0, due_last, at;
    dc0 = done_cnt;
    start(4'd2, 4'd3, 8'd2);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (bus.io_in_ready !== 1'b1) begin errors++; $display("FAIL rep_ready step %0d: got %b expected 1", i, bus.io_in_ready); end
      due_last = cyc + LAT;
      issue(1'b1, (i % 2 == 1) ? 4'd3 : 4'd2);
    end
    wait_done(at);
    checks++; if (at != due_last + 1) begin errors++; $display("FAIL rep_done_cyc: got %0d expected %0d", at, due_last + 1); end
    repeat (4) tick();
    checks++; if (done_cnt - dc0 != 1) begin errors++; $display("FAIL rep_done_cnt: got %0d expected 1", done_cnt - dc0); end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL rep_sb_left: got %0d expected 0", sb.size()); end
  endtask

  task automatic test_gaps();
    int due_last, at;
    start(4'd4, 4'd5, 8'd1);
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (bus.io_in_ready !== 1'b1) begin errors++; $display("FAIL gap_ready cyc %0d: got %b expected 1", i, bus.io_in_ready); end
      if (i % 2 == 0) due_last = cyc + LAT;
      issue(i % 2 == 0, 4'd4 + 4'((i / 2) % 2));
    end
    wait_done(at);
    checks++; if (at != due_last + 1) begin errors++; $display("FAIL gap_done_cyc: got %0d expected %0d", at, due_last + 1); end
    tick();
  endtask

  task automatic test_bad_range();
    int dc0;
    dc0 = done_cnt;
    start(4'd5, 4'd4, 8'd0);
    checks++; if (bus.io_busy !== 1'b0) begin errors++; $display("FAIL bad_busy: got %b expected 0", bus.io_busy); end
    checks++; if (bus.io_in_ready !== 1'b0) begin errors++; $display("FAIL bad_ready: got %b expected 0", bus.io_in_ready); end
    repeat (6) tick();
    checks++; if (done_cnt != dc0) begin errors++; $display("FAIL bad_done: got %0d pulses expected 0", done_cnt - dc0); end
  endtask

  task automatic test_busy_ignore();
    int due_last, at;
    logic [25:0] orig;
    orig = tbl_m[0];
    start(4'd0, 4'd3, 8'd0);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        bus.io_cfg_wen   = 1'b1;
        bus.io_cfg_waddr = 4'd0;
        bus.io_cfg_wdata = ~orig;
        bus.io_start     = 1'b1;
        bus.io_first     = 4'd2;
        bus.io_last      = 4'd3;
      end
      due_last = cyc + LAT;
      issue(1'b1, i[3:0]);
      bus.io_cfg_wen = 1'b0;
      bus.io_start   = 1'b0;
    end
    wait_done(at);
    checks++; if (at != due_last + 1) begin errors++; $display("FAIL busy_done_cyc: got %0d expected %0d", at, due_last + 1); end
    tick();
    start(4'd0, 4'd0, 8'd0);
    due_last = cyc + LAT;
    issue(1'b1, 4'd0);
    checks++; if (cfg_out() !== orig) begin errors++; $display("FAIL busy_tbl0: got %h expected %h", cfg_out(), orig); end
    wait_done(at);
    checks++; if (at != due_last + 1) begin errors++; $display("FAIL busy_rerun_done: got %0d expected %0d", at, due_last + 1); end
    tick();
  endtask

  task automatic test_reset_mid();
    int dc0, due_last, at;
    start(4'd0, 4'd3, 8'd0);
    issue(1'b1, 4'd0);
    issue(1'b1, 4'd1);
    dc0 = done_cnt;
    reset = 1'b1;
    bus.io_in_valid = 1'b1;
    sb.delete();
    tick();
    exp_cfg = '0;
    exp_ops = '0;
    reset = 1'b0;
    checks++; if (bus.io_busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", bus.io_busy); end
    checks++; if (bus.io_in_ready !== 1'b0) begin errors++; $display("FAIL mid_ready: got %b expected 0", bus.io_in_ready); end
    checks++; if (bus.io_out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b expected 0", bus.io_out_valid); end
    checks++; if (bus.io_round !== 3'd0) begin errors++; $display("FAIL mid_round: got %0d expected 0", bus.io_round); end
    repeat (8) tick();
    bus.io_in_valid = 1'b0;
    checks++; if (done_cnt != dc0) begin errors++; $display("FAIL mid_done: got %0d pulses expected 0", done_cnt - dc0); end
    start(4'd0, 4'd3, 8'd0);
    for (int i = 0; i < 4; i++) begin
      due_last = cyc + LAT;
      issue(1'b1, i[3:0]);
    end
    wait_done(at);
    checks++; if (at != due_last + 1) begin errors++; $display("FAIL mid_rerun_done: got %0d expected %0d", at, due_last + 1); end
    tick();
  endtask

  initial begin
    bus.io_cfg_wen = 0; bus.io_cfg_waddr = '0; bus.io_cfg_wdata = '0;
    bus.io_start = 0; bus.io_first = '0; bus.io_last = '0; bus.io_repeat = '0;
    bus.io_in_valid = 0; bus.io_Xi_0 = '0; bus.io_Yi_0 = '0; bus.io_Xi_1 = '0; bus.io_Yi_1 = '0;
    test_reset();
    for (int i = 0; i < 16; i++) wr(i[3:0], 26'($urandom));
    test_basic();
    test_repeat();
    test_gaps();
    test_bad_range();
    test_busy_ignore();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
